// File: rtl/router_input_requester_pkg.sv
// Shared definitions for the router input-port requester: flit type codes,
// FSM state encoding, output-port indices and header field offsets.
package router_input_requester_pkg;

  // Flit type codes (one-hot).
  localparam logic [2:0] FlitHeader = 3'b001;
  localparam logic [2:0] FlitBody   = 3'b010;
  localparam logic [2:0] FlitTail   = 3'b100;

  // Requester states (one-hot).
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StReq  = 3'b010,
    StXfer = 3'b100
  } state_e;

  // Output port indices; req/gnt bit order is {W,S,E,N,L}.
  localparam int unsigned NumPorts = 5;
  localparam int unsigned PortL    = 0;
  localparam int unsigned PortN    = 1;
  localparam int unsigned PortE    = 2;
  localparam int unsigned PortS    = 3;
  localparam int unsigned PortW    = 4;

  // Header payload layout; dst_y follows dst_x and depends on the coordinate width.
  localparam int unsigned LenLsb  = 0;
  localparam int unsigned LenW    = 12;
  localparam int unsigned DstXLsb = 12;

  // Saturating increment for the 12-bit flit counter.
  function automatic logic [LenW-1:0] sat_inc(input logic [LenW-1:0] v);
    return (v == {LenW{1'b1}}) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/router_input_requester_xy_route_calc.sv
// Combinational XY (X-first) route computation: destination coordinates in,
// one-hot output port {W,S,E,N,L} out.
module xy_route_calc
  import router_input_requester_pkg::*;
#(
  parameter int unsigned COORD_W = 1,
  parameter int unsigned CUR_X   = 0,
  parameter int unsigned CUR_Y   = 0
) (
  input  logic [COORD_W-1:0]  dst_x_i,
  input  logic [COORD_W-1:0]  dst_y_i,
  output logic [NumPorts-1:0] port_oh_o
);

  localparam logic [COORD_W-1:0] CurX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CurY = COORD_W'(CUR_Y);

  // Resolve X first; only a matching X column looks at Y.
  always_comb begin
    port_oh_o = '0;
    if (dst_x_i > CurX) begin
      port_oh_o[PortE] = 1'b1;
    end else if (dst_x_i < CurX) begin
      port_oh_o[PortW] = 1'b1;
    end else if (dst_y_i > CurY) begin
      port_oh_o[PortS] = 1'b1;
    end else if (dst_y_i < CurY) begin
      port_oh_o[PortN] = 1'b1;
    end else begin
      port_oh_o[PortL] = 1'b1;
    end
  end

endmodule

// File: rtl/router_input_requester.sv
// Router input-port requester: decodes the HEADER at the head of the input
// FIFO, requests the XY-routed output port and streams the packet while
// granted, releasing the request after the TAIL flit.
// Optional: define ROUTER_LEN_CHECK_EN to add a sticky packet-length error output err_o.
module router_input_requester
  import router_input_requester_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COORD_W = 1,
  parameter int unsigned CUR_X   = 0,
  parameter int unsigned CUR_Y   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty_i,
  input  logic [2:0]          fifo_flit_type_i,
  input  logic [DATA_W-1:0]   fifo_data_i,
  output logic                fifo_rd_en_o,
  input  logic [NumPorts-1:0] gnt_i,
  input  logic                out_ready_i,
  output logic [NumPorts-1:0] req_o,
  output logic [2:0]          req_flit_type_o,
  output logic [LenW-1:0]     req_length_o,
  output logic                out_valid_o,
  output logic [2:0]          out_flit_type_o,
  output logic [DATA_W-1:0]   out_data_o
`ifdef ROUTER_LEN_CHECK_EN
  ,
  output logic                err_o
`endif
);

  state_e              state_q, state_d;
  logic [NumPorts-1:0] req_q, req_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [LenW-1:0]     cnt_q, cnt_d;
  logic                ov_q, ov_d;
  logic [2:0]          oft_q, oft_d;
  logic [DATA_W-1:0]   od_q, od_d;

  logic [COORD_W-1:0]  dst_x, dst_y;
  logic [NumPorts-1:0] route_oh;
  logic                head_is_hdr, head_is_tail, discard, xfer_pop;

  assign dst_x = fifo_data_i[DstXLsb +: COORD_W];
  assign dst_y = fifo_data_i[DstXLsb + COORD_W +: COORD_W];

  xy_route_calc #(
    .COORD_W (COORD_W),
    .CUR_X   (CUR_X),
    .CUR_Y   (CUR_Y)
  ) u_route (
    .dst_x_i   (dst_x),
    .dst_y_i   (dst_y),
    .port_oh_o (route_oh)
  );

  // Decode the FIFO head and the pop conditions for this cycle.
  always_comb begin
    head_is_hdr  = !fifo_empty_i && (fifo_flit_type_i == FlitHeader);
    head_is_tail = (fifo_flit_type_i == FlitTail);
    // Stray non-HEADER flits at an idle port belong to no packet: drop them.
    discard      = (state_q == StIdle) && !fifo_empty_i && (fifo_flit_type_i != FlitHeader);
    xfer_pop     = (state_q != StIdle) && |(gnt_i & req_q) && !fifo_empty_i && out_ready_i;
    fifo_rd_en_o = !rst && (discard || xfer_pop);
    req_flit_type_o = ((state_q != StIdle) && !fifo_empty_i) ? fifo_flit_type_i : 3'b000;
  end

  // Next-state logic for the request FSM, counter and output flit register.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ov_d    = xfer_pop;
    oft_d   = oft_q;
    od_d    = od_q;
    if (xfer_pop) begin
      oft_d = fifo_flit_type_i;
      od_d  = fifo_data_i;
    end
    unique case (state_q)
      StIdle: begin
        if (head_is_hdr) begin
          state_d = StReq;
          req_d   = route_oh;
          len_d   = fifo_data_i[LenLsb +: LenW];
        end
      end
      StReq: begin
        if (xfer_pop) begin
          state_d = StXfer;
          cnt_d   = 12'd1;
        end
      end
      StXfer: begin
        if (xfer_pop) begin
          if (head_is_tail) begin
            state_d = StIdle;
            req_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      oft_q   <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      oft_q   <= oft_d;
      od_q    <= od_d;
    end
  end

  assign req_o           = req_q;
  assign req_length_o    = len_q;
  assign out_valid_o     = ov_q;
  assign out_flit_type_o = oft_q;
  assign out_data_o      = od_q;

`ifdef ROUTER_LEN_CHECK_EN
  logic        err_q, err_d;
  logic [12:0] cnt_inc;

  // Sticky length/framing error: wrong TAIL position, missing TAIL, stray flit, short header.
  always_comb begin
    err_d   = err_q;
    cnt_inc = {1'b0, cnt_q} + 13'd1;
    if (discard) begin
      err_d = 1'b1;
    end
    if ((state_q == StIdle) && head_is_hdr && (fifo_data_i[LenLsb +: LenW] < 12'd2)) begin
      err_d = 1'b1;
    end
    if (xfer_pop) begin
      if (head_is_tail) begin
        if (cnt_inc != {1'b0, len_q}) err_d = 1'b1;
      end else if (cnt_inc >= {1'b0, len_q}) begin
        err_d = 1'b1;
      end
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_router_input_requester.sv
// Self-checking bench for router_input_requester: directed packet scenarios
// followed by randomized traffic, checked every cycle against a packet-level
// reference model. Define ROUTER_LEN_CHECK_EN to also check err_o.
module tb_router_input_requester;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COORD_W = 1;
  localparam int          CUR_X   = 0;
  localparam int          CUR_Y   = 0;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  typedef struct {
    logic [2:0]        t;
    logic [DATA_W-1:0] d;
  } flit_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [2:0]        fifo_flit_type = '0;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_rd_en;
  logic [4:0]        gnt = '0;
  logic              out_ready = 1'b0;
  logic [4:0]        req;
  logic [2:0]        req_flit_type;
  logic [11:0]       req_length;
  logic              out_valid;
  logic [2:0]        out_flit_type;
  logic [DATA_W-1:0] out_data;
`ifdef ROUTER_LEN_CHECK_EN
  logic              err;
`endif

  router_input_requester #(
    .DATA_W  (DATA_W),
    .COORD_W (COORD_W),
    .CUR_X   (CUR_X),
    .CUR_Y   (CUR_Y)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty_i     (fifo_empty),
    .fifo_flit_type_i (fifo_flit_type),
    .fifo_data_i      (fifo_data),
    .fifo_rd_en_o     (fifo_rd_en),
    .gnt_i            (gnt),
    .out_ready_i      (out_ready),
    .req_o            (req),
    .req_flit_type_o  (req_flit_type),
    .req_length_o     (req_length),
    .out_valid_o      (out_valid),
    .out_flit_type_o  (out_flit_type),
    .out_data_o       (out_data)
`ifdef ROUTER_LEN_CHECK_EN
    ,
    .err_o            (err)
`endif
  );

  always #5 clk = ~clk;

  flit_t fq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Packet-level reference model.
  bit                m_busy;
  logic [4:0]        m_port;
  logic [11:0]       m_len;
  int                m_cnt;
  bit                m_err;
  bit                e_ov;
  logic [2:0]        e_oft;
  logic [DATA_W-1:0] e_od;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] route(input int dx, input int dy);
    if (dx > CUR_X) return 5'b00100;
    if (dx < CUR_X) return 5'b10000;
    if (dy > CUR_Y) return 5'b01000;
    if (dy < CUR_Y) return 5'b00010;
    return 5'b00001;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_port = '0;
    m_len  = '0;
    m_cnt  = 0;
    m_err  = 0;
    e_ov   = 0;
    e_oft  = '0;
    e_od   = '0;
  endtask

  // Queue one packet: header, bodies, and TAIL at flit index tail_pos.
  task automatic push_pkt(input int dx, input int dy, input int len, input int tail_pos);
    flit_t f;
    f.t = HDR;
    f.d = $urandom;
    f.d[11:0] = 12'(len);
    f.d[12] = 1'(dx);
    f.d[13] = 1'(dy);
    fq.push_back(f);
    for (int i = 1; i < tail_pos; i++) begin
      f.t = BODY;
      f.d = $urandom;
      fq.push_back(f);
    end
    f.t = TAIL;
    f.d = $urandom;
    fq.push_back(f);
  endtask

  task automatic push_stray();
    flit_t f;
    f.t = BODY;
    f.d = $urandom;
    fq.push_back(f);
  endtask

  // One clock: drive inputs, check at negedge against the model, advance model.
  task automatic cycle(input bit r, input int gnt_pct, input int rdy_pct, input int emp_pct);
    bit pop_exp, xfer_exp;
    rst = r;
    fifo_empty = (fq.size() == 0) || (int'($urandom_range(99)) < emp_pct);
    if (fq.size() != 0) begin
      fifo_flit_type = fq[0].t;
      fifo_data      = fq[0].d;
    end else begin
      fifo_flit_type = 3'($urandom);
      fifo_data      = $urandom;
    end
    out_ready = int'($urandom_range(99)) < rdy_pct;
    if (gnt_pct == 0) gnt = '0;
    else if (int'($urandom_range(99)) < gnt_pct) gnt = m_port;
    else gnt = 5'b00001 << $urandom_range(4);

    @(negedge clk);
    xfer_exp = !r && m_busy && ((gnt & m_port) != 0) && !fifo_empty && out_ready;
    pop_exp  = xfer_exp || (!r && !m_busy && !fifo_empty && fifo_flit_type != HDR);

    check_eq("req", req, m_busy ? m_port : 5'b0);
    check_eq("req_length", req_length, m_len);
    check_eq("req_flit_type", req_flit_type, (m_busy && !fifo_empty) ? fifo_flit_type : 3'b0);
    check_eq("fifo_rd_en", fifo_rd_en, pop_exp);
    check_eq("out_valid", out_valid, e_ov);
    if (e_ov) begin
      check_eq("out_flit_type", out_flit_type, e_oft);
      check_eq("out_data", out_data, e_od);
    end
`ifdef ROUTER_LEN_CHECK_EN
    check_eq("err", err, m_err);
`endif

    if (r) begin
      model_reset();
    end else begin
      e_ov = xfer_exp;
      if (xfer_exp) begin
        e_oft = fifo_flit_type;
        e_od  = fifo_data;
      end
      if (!m_busy) begin
        if (!fifo_empty && fifo_flit_type == HDR) begin
          m_busy = 1;
          m_port = route(int'(fifo_data[12]), int'(fifo_data[13]));
          m_len  = fifo_data[11:0];
          m_cnt  = 0;
          if (m_len < 2) m_err = 1;
        end else if (!fifo_empty) begin
          m_err = 1;
        end
      end else if (xfer_exp) begin
        if (fifo_flit_type == TAIL) begin
          if (m_cnt + 1 != int'(m_len)) m_err = 1;
          m_busy = 0;
          m_cnt  = 0;
        end else begin
          if (m_cnt + 1 >= int'(m_len)) m_err = 1;
          if (m_cnt < 4095) m_cnt++;
        end
      end
    end

    if (fifo_rd_en === 1'b1 && fq.size() != 0) void'(fq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int gnt_pct, input int rdy_pct, input int emp_pct);
    for (int i = 0; i < n; i++) cycle(0, gnt_pct, rdy_pct, emp_pct);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then a 3-flit packet east with a steady grant.
    run(2, 100, 100, 0);
    push_pkt(1, 0, 3, 2);
    run(7, 100, 100, 0);

    // Same packet with the grant withheld for several cycles.
    push_pkt(1, 0, 3, 2);
    run(5, 0, 100, 0);
    run(6, 100, 100, 0);

    // Local 2-flit packet with out_ready toggling 1,0,1.
    push_pkt(0, 0, 2, 1);
    cycle(0, 100, 100, 0);
    cycle(0, 100, 100, 0);
    cycle(0, 100, 0, 0);
    cycle(0, 100, 100, 0);
    run(3, 100, 100, 0);

    // Stray BODY at an idle port.
    push_stray();
    run(3, 100, 100, 0);

    // Reset after 2 of 4 flits; leftovers are discarded, next packet goes through.
    push_pkt(1, 1, 4, 3);
    run(3, 100, 100, 0);
    cycle(1, 100, 100, 0);
    push_pkt(1, 0, 3, 2);
    run(10, 100, 100, 0);

    // Length 4 but TAIL arrives as the 3rd flit.
    push_pkt(1, 0, 4, 2);
    run(8, 100, 100, 0);

    // Randomized traffic with back-to-back packets, stalls, strays and resets.
    for (int it = 0; it < 250; it++) begin
      int len;
      int gp;
      len = int'($urandom_range(2, 6));
      if ($urandom_range(99) < 60) begin
        push_pkt(int'($urandom_range(1)), int'($urandom_range(1)), len, len - 1);
      end
      if ($urandom_range(99) < 3) push_stray();
      if ($urandom_range(99) < 2) cycle(1, 100, 100, 0);
      case ($urandom_range(2))
        0:       gp = 0;
        1:       gp = 50;
        default: gp = 90;
      endcase
      run(int'($urandom_range(1, 10)), gp, int'($urandom_range(40, 100)),
          int'($urandom_range(0, 40)));
    end

    // Drain, bounded.
    guard = 0;
    while ((fq.size() != 0 || m_busy) && guard < 2000) begin
      cycle(0, 100, 100, 0);
      guard++;
    end
    check_eq("drain_done", {63'b0, guard < 2000}, 64'd1);
    run(3, 100, 100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
